// File: rtl/keyword_pkg.sv
// keyword_pkg: keyword code constants and sequencer FSM state encoding.
package keyword_pkg;
    typedef enum logic [3:0] {
        KW_SILENCE    = 4'd0,
        KW_WAKE       = 4'd1,
        KW_CMD_LIGHTS = 4'd2,
        KW_CMD_MUSIC  = 4'd3,
        KW_CMD_STOP   = 4'd4,
        KW_CMD_UP     = 4'd5,
        KW_CMD_DOWN   = 4'd6
    } keyword_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } seq_state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: power-of-two circular command queue with push/pop, full/empty and occupancy.
module cmd_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    assign w_pop  = pop && !empty;
    // a pop frees the slot in the same cycle, so a full queue can still accept
    assign w_push = push && (!full || w_pop);
    assign full   = r_count == CW'(DEPTH);
    assign empty  = r_count == '0;
    assign count  = r_count;
    assign dout   = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/keyword_command_sequencer.sv
// keyword_command_sequencer: wake keyword arms a timed window; the next keyword becomes a queued command.
module keyword_command_sequencer
    import keyword_pkg::*;
#(
    parameter logic [3:0] WAKE_CODE      = KW_WAKE,
    parameter logic [3:0] SILENCE_CODE   = KW_SILENCE,
    parameter int         TIMEOUT_CYCLES = 100_000_000,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keyword_in,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] cmd_code,
    output logic       armed,
    output logic       timeout_pulse,
    output logic       drop_pulse
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    seq_state_t                  r_state;
    logic [3:0]                  r_kw_prev;
    logic [TW-1:0]               r_timer;
    logic                        r_armed;
    logic                        r_timeout;
    logic                        r_drop;
    logic                        w_event;
    logic                        w_wake;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [3:0]                  w_head;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    // one event per transition into a non-silence code
    assign w_event = keyword_in != r_kw_prev && keyword_in != SILENCE_CODE;
    assign w_wake  = w_event && keyword_in == WAKE_CODE;
    assign w_push  = r_state == ST_ARMED && w_event && !w_wake;
    assign w_pop   = cmd_valid && cmd_ready;
    assign cmd_valid     = w_count != '0;
    assign cmd_code      = w_empty ? '0 : w_head;
    assign armed         = r_armed;
    assign timeout_pulse = r_timeout;
    assign drop_pulse    = r_drop;
    cmd_fifo #(.W(4), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (keyword_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_kw_prev <= SILENCE_CODE;
            r_timer   <= '0;
            r_armed   <= 1'b0;
            r_timeout <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_kw_prev <= keyword_in;
            r_timeout <= 1'b0;
            r_drop    <= w_push && w_full && !w_pop;
            if (r_state == ST_IDLE) begin
                if (w_wake) begin
                    r_state <= ST_ARMED;
                    r_timer <= TIMER_LOAD;
                    r_armed <= 1'b1;
                end
            end else if (w_wake) begin
                r_timer <= TIMER_LOAD;
            end else if (w_event) begin
                r_state <= ST_IDLE;
                r_armed <= 1'b0;
            end else if (r_timer != '0) begin
                r_timer <= r_timer - TW'(1);
            end else begin
                r_state   <= ST_IDLE;
                r_armed   <= 1'b0;
                r_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_keyword_command_sequencer.sv
// tb_keyword_command_sequencer: directed + random stimulus against a deadline-based reference model with a command scoreboard.
module tb_keyword_command_sequencer;
    localparam int TMO = 16;
    localparam int DEP = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keyword_in = 4'd0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       armed;
    logic       timeout_pulse;
    logic       drop_pulse;
    int total = 0;
    int bad = 0;
    int n_to_seen = 0;
    int n_drop_seen = 0;
    int n_cmd_seen = 0;
    // reference model state
    logic [3:0] sb_cmd[$];
    logic [3:0] m_prev = 4'd0;
    bit   m_armed = 0;
    bit   m_to = 0;
    bit   m_drop = 0;
    int   occ = 0;
    int   cyc = 0;
    int   m_wake = 0;

    keyword_command_sequencer #(
        .WAKE_CODE(4'd1), .SILENCE_CODE(4'd0), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .keyword_in(keyword_in), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_code(cmd_code), .armed(armed),
        .timeout_pulse(timeout_pulse), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: window ends TMO edges after the most recent wake event
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed = 0; m_prev = 4'd0; occ = 0; m_to = 0; m_drop = 0;
            sb_cmd.delete();
        end else begin
            bit ev;
            bit pop;
            ev = keyword_in != m_prev && keyword_in != 4'd0;
            pop = occ > 0 && cmd_ready;
            m_to = 0;
            m_drop = 0;
            if (pop) occ--;
            if (!m_armed) begin
                if (ev && keyword_in == 4'd1) begin m_armed = 1; m_wake = cyc; end
            end else if (ev && keyword_in == 4'd1) begin
                m_wake = cyc;
            end else if (ev) begin
                m_armed = 0;
                if (occ < DEP) begin occ++; sb_cmd.push_back(keyword_in); end
                else m_drop = 1;
            end else if (cyc - m_wake == TMO) begin
                m_armed = 0;
                m_to = 1;
            end
            m_prev = keyword_in;
            cyc++;
        end
    end

    // monitor: sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", {cmd_valid, cmd_code, armed, timeout_pulse, drop_pulse}, 0);
        end else begin
            chk("armed", armed, m_armed);
            chk("timeout_pulse", timeout_pulse, m_to);
            chk("drop_pulse", drop_pulse, m_drop);
            chk("cmd_valid", cmd_valid, occ > 0);
            if (timeout_pulse) n_to_seen++;
            if (drop_pulse) n_drop_seen++;
            if (cmd_valid) begin
                if (sb_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
                else begin
                    chk("cmd_code", cmd_code, sb_cmd[0]);
                    if (cmd_ready) begin void'(sb_cmd.pop_front()); n_cmd_seen++; end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [3:0] code, input int hold);
        keyword_in = code;
        repeat (hold) step();
    endtask

    initial begin
        int n0;
        int d0;
        int c0;
        repeat (3) step();
        rst = 1'b0;
        send(0, 2);
        // wake then command
        c0 = n_cmd_seen;
        send(1, 5); send(3, 5);
        chk("req035_cmds", n_cmd_seen - c0, 1);
        // timeout after holding wake
        send(0, 2);
        n0 = n_to_seen;
        send(1, 20);
        chk("req036_timeouts", n_to_seen - n0, 1);
        // non-wake code in idle ignored; wake re-arm reloads
        send(0, 2);
        c0 = n_cmd_seen;
        send(3, 3); send(1, 10); send(0, 1); send(1, 14);
        chk("req037_still_armed", armed, 1);
        send(1, 3);
        chk("req037_expired", armed, 0);
        chk("req037_no_cmd", n_cmd_seen - c0, 0);
        // full queue drop
        send(0, 2);
        cmd_ready = 1'b0;
        d0 = n_drop_seen;
        for (int c = 2; c <= 6; c++) begin send(1, 2); send(c[3:0], 2); send(0, 1); end
        chk("req038_drops", n_drop_seen - d0, 1);
        c0 = n_cmd_seen;
        cmd_ready = 1'b1;
        send(0, 8);
        chk("req038_drained", n_cmd_seen - c0, 4);
        // command on the timer==0 cycle
        n0 = n_to_seen;
        send(1, TMO); send(5, 1); send(0, 4);
        chk("req039_no_timeout", n_to_seen - n0, 0);
        // reset mid-window with queued commands
        cmd_ready = 1'b0;
        send(1, 2); send(2, 2); send(1, 2); send(3, 2); send(1, 3);
        rst = 1'b1;
        #1;
        chk("req040_valid_drop", cmd_valid, 0);
        chk("req040_armed_drop", armed, 0);
        repeat (2) step();
        cmd_ready = 1'b1;
        rst = 1'b0;
        step();
        chk("req040_rearm", armed, 1);
        // random phase
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [3:0] k;
            r = $urandom_range(0, 9);
            k = (r < 3) ? 4'd0 : (r < 6) ? 4'd1 : 4'($urandom_range(2, 15));
            cmd_ready = $urandom_range(0, 3) != 0;
            send(k, ($urandom_range(0, 15) == 0) ? 18 : $urandom_range(1, 3));
        end
        cmd_ready = 1'b1;
        send(0, 10);
        chk("final_sb_empty", sb_cmd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keyword_command_sequencer.md
KEYWORD_COMMAND_SEQUENCER -- requirements
Module: keyword_command_sequencer

Interface
REQ-001 SHALL have parameter WAKE_CODE, default 4'd1, keyword code that arms the sequencer.
REQ-002 SHALL have parameter SILENCE_CODE, default 4'd0, keyword code meaning no keyword.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, armed-window length in clk cycles (>=2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port keyword_in  input  4  debounced keyword code from the debounce stage, synchronous to clk.
REQ-008 SHALL have port cmd_valid  output  1  queue head holds a command.
REQ-009 SHALL have port cmd_ready  input  1  consumer accepts head this cycle.
REQ-010 SHALL have port cmd_code  output  4  command code at queue head.
REQ-011 SHALL have port armed  output  1  sequencer in ARMED state.
REQ-012 SHALL have port timeout_pulse  output  1  one-cycle pulse when the armed window expires.
REQ-013 SHALL have port drop_pulse  output  1  one-cycle pulse when a command is discarded due to a full queue.

Function
REQ-014 SHALL hold kw_prev register; event at an edge when keyword_in != kw_prev and keyword_in != SILENCE_CODE; kw_prev <= keyword_in every edge.
REQ-015 SHALL NOT generate an event on a change to SILENCE_CODE, nor on a held code (one event per transition).
REQ-016 SHALL implement FSM states IDLE and ARMED.
REQ-017 IDLE: event with WAKE_CODE -> ARMED, timer <= TIMEOUT_CYCLES-1; other events ignored.
REQ-018 ARMED: event with WAKE_CODE -> stay ARMED, timer reloaded to TIMEOUT_CYCLES-1.
REQ-019 ARMED: event with any other code -> push code to queue, -> IDLE.
REQ-020 ARMED, no event: timer !=0 -> decrement; timer ==0 -> IDLE, timeout_pulse=1 next cycle only.
REQ-021 Event and timer==0 in same cycle: event SHALL win; no timeout_pulse.
REQ-022 Push with queue full and no pop in same cycle: code discarded, drop_pulse=1 one cycle, FSM still -> IDLE.
REQ-023 Push and pop in same cycle when full: both SHALL occur, no drop.
REQ-024 cmd_valid SHALL be high the cycle after a push into an empty queue (1-cycle latency from sampled keyword).
REQ-025 Pop SHALL occur when cmd_valid && cmd_ready; cmd_code SHALL hold stable while cmd_valid && !cmd_ready.
REQ-026 Queue SHALL be FIFO order; pointers wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-027 armed SHALL be a registered decode of state (high exactly while state==ARMED).

Reset
REQ-028 rst high SHALL asynchronously force: state=IDLE, kw_prev=SILENCE_CODE, timer=0, queue empty.
REQ-029 During reset outputs SHALL be cmd_valid=0, cmd_code=0, armed=0, timeout_pulse=0, drop_pulse=0.
REQ-030 Reset mid-window or with queued commands SHALL discard all state; no pulses on release.
REQ-031 First edge after release with keyword_in != SILENCE_CODE SHALL count as an event.

Structure
REQ-032 Package keyword_pkg SHALL hold keyword code constants (SILENCE, WAKE, command codes) and the FSM state encoding.
REQ-033 Queue SHALL be a sub-module cmd_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-034 Timer width SHALL be clog2(TIMEOUT_CYCLES); no other sub-modules.

Verification (TIMEOUT_CYCLES=16, FIFO_DEPTH=4, cmd_ready=1 unless stated)
REQ-035 keyword_in 0->1->3 (each held 5 cycles) -> armed high after 1, one push of 3, cmd_valid=1 cmd_code=3 one cycle, armed low.
REQ-036 keyword_in 0->1 held 20 cycles -> armed high 16 cycles, timeout_pulse exactly once, no command.
REQ-037 keyword_in 3 while IDLE, then 1->0->1 at cycle 10 of window -> no command for 3; timer reloaded, window ends 16 cycles after second 1.
REQ-038 cmd_ready=0, five wake/command pairs codes 2,3,4,5,6 -> queue holds 2,3,4,5; drop_pulse once (code 6); then cmd_ready=1 drains 2,3,4,5 in order.
REQ-039 Command event on the cycle timer==0 -> command pushed, timeout_pulse stays 0.
REQ-040 rst asserted mid-window with 2 queued -> cmd_valid/armed drop immediately; after release, held keyword 1 re-arms.
